// File: rtl/control_signals_pkg.sv
// control_signals: strobe indices driven by the control unit into the datapath.
package control_signals;

    typedef enum logic [3:0] {
        CtrlUpdateFlagNegative,
        CtrlUpdateFlagZero,
        CtrlUpdateFlagCarry,
        CtrlUpdateFlagOverflow,
        CtrlSetFlagCarry,
        CtrlClearFlagCarry,
        CtrlSetFlagInterrupt,
        CtrlClearFlagInterrupt,
        CtrlSetFlagDecimal,
        CtrlClearFlagDecimal,
        CtrlClearFlagOverflow,
        CtrlLoadStatus,
        CtrlStatusBitTest,
        CtrlSignalEndMarker
    } ctrl_signal_t;

    localparam int CTRL_SIGNAL_COUNT = int'(CtrlSignalEndMarker);

endpackage

// File: rtl/processor_status_pkg.sv
// processor_status: flag index map and P-byte constants shared with the control unit.
package processor_status;

    // Order is load-bearing: the control unit branches on status_flags[opcode[7:6]].
    typedef enum logic [2:0] {
        FlagNegative = 3'd0,
        FlagOverflow,
        FlagCarry,
        FlagZero,
        FlagInterrupt,
        FlagDecimal,
        FlagBreak,
        FlagUnused
    } flag_index_t;

    localparam logic [7:0] STATUS_BIT5_MASK = 8'h20;
    localparam int         STATUS_BREAK_BIT = 4;

endpackage

// File: rtl/status_register.sv
// status_register: 6502 P register with per-flag priority update from control strobes.
module status_register
    import control_signals::*;
    import processor_status::*;
#(
    parameter logic RESET_I_FLAG = 1'b1,
    parameter logic RESET_D_FLAG = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ctrl_signals [CTRL_SIGNAL_COUNT],
    input  logic [7:0] data_bus,
    input  logic       alu_carry_out,
    input  logic       alu_overflow_out,
    input  logic       brk_push,
    output logic       status_flags [8],
    output logic [7:0] status_byte,
    output logic       alu_carry_in
);

    logic n_q, v_q, b_q, d_q, i_q, z_q, c_q;
    logic n_d, v_d, d_d, i_d, z_d, c_d;
    logic load, bit_test;

    assign load     = ctrl_signals[CtrlLoadStatus];
    assign bit_test = ctrl_signals[CtrlStatusBitTest];

    // Load beats clear beats set beats update; BIT overrides the N/V updates only.
    always_comb begin
        n_d = load ? data_bus[7]
            : (bit_test || ctrl_signals[CtrlUpdateFlagNegative]) ? data_bus[7] : n_q;
        v_d = load ? data_bus[6]
            : ctrl_signals[CtrlClearFlagOverflow] ? 1'b0
            : bit_test ? data_bus[6]
            : ctrl_signals[CtrlUpdateFlagOverflow] ? alu_overflow_out : v_q;
        z_d = load ? data_bus[1]
            : ctrl_signals[CtrlUpdateFlagZero] ? (data_bus == 8'h00) : z_q;
        c_d = load ? data_bus[0]
            : ctrl_signals[CtrlClearFlagCarry] ? 1'b0
            : ctrl_signals[CtrlSetFlagCarry] ? 1'b1
            : ctrl_signals[CtrlUpdateFlagCarry] ? alu_carry_out : c_q;
        i_d = load ? data_bus[2]
            : ctrl_signals[CtrlClearFlagInterrupt] ? 1'b0
            : ctrl_signals[CtrlSetFlagInterrupt] ? 1'b1 : i_q;
        d_d = load ? data_bus[3]
            : ctrl_signals[CtrlClearFlagDecimal] ? 1'b0
            : ctrl_signals[CtrlSetFlagDecimal] ? 1'b1 : d_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {n_q, v_q, b_q, z_q, c_q} <= 5'b0;
            i_q <= RESET_I_FLAG;
            d_q <= RESET_D_FLAG;
        end else begin
            {n_q, v_q, d_q, i_q, z_q, c_q} <= {n_d, v_d, d_d, i_d, z_d, c_d};
        end
    end

    assign status_flags[FlagNegative]  = n_q;
    assign status_flags[FlagOverflow]  = v_q;
    assign status_flags[FlagCarry]     = c_q;
    assign status_flags[FlagZero]      = z_q;
    assign status_flags[FlagInterrupt] = i_q;
    assign status_flags[FlagDecimal]   = d_q;
    assign status_flags[FlagBreak]     = b_q;
    assign status_flags[FlagUnused]    = 1'b0;

    assign status_byte  = {n_q, v_q, 1'b0, brk_push | b_q, d_q, i_q, z_q, c_q} | STATUS_BIT5_MASK;
    assign alu_carry_in = c_q;

endmodule

// File: tb/tb_status_register.sv
// tb_status_register: directed vectors with a scoreboard queue checked by a separate monitor.
module tb_status_register;
    import control_signals::*;
    import processor_status::*;

    typedef struct {
        string      name;
        logic [7:0] sb;
        logic [7:0] fl;
        logic       cin;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ctrl [CTRL_SIGNAL_COUNT];
    logic [7:0] data_bus;
    logic       alu_carry_out, alu_overflow_out, brk_push;
    logic       status_flags [8];
    logic [7:0] status_byte;
    logic       alu_carry_in;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    status_register dut (
        .clk(clk), .reset(reset), .ctrl_signals(ctrl), .data_bus(data_bus),
        .alu_carry_out(alu_carry_out), .alu_overflow_out(alu_overflow_out),
        .brk_push(brk_push), .status_flags(status_flags),
        .status_byte(status_byte), .alu_carry_in(alu_carry_in)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] m(input ctrl_signal_t s);
        return 13'(1) << s;
    endfunction

    // Expected flags vector index order: 0=N 1=V 2=C 3=Z 4=I 5=D 6=B 7=0.
    function automatic exp_t ex(input string nm, input logic n, input logic v, input logic c,
                                input logic z, input logic i, input logic d, input logic brk);
        exp_t e;
        e.name = nm;
        e.sb   = {n, v, 1'b1, brk, d, i, z, c};
        e.fl   = {1'b0, 1'b0, d, i, z, c, v, n};
        e.cin  = c;
        return e;
    endfunction

    task automatic step(input logic rst, input logic [12:0] mask, input logic [7:0] bus,
                        input logic co, input logic ov, input logic brk, input exp_t e);
        @(negedge clk);
        #1;
        reset = rst;
        for (int k = 0; k < CTRL_SIGNAL_COUNT; k++) ctrl[k] = mask[k];
        data_bus = bus;
        alu_carry_out = co;
        alu_overflow_out = ov;
        brk_push = brk;
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [7:0] af;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                af = {status_flags[7], status_flags[6], status_flags[5], status_flags[4],
                      status_flags[3], status_flags[2], status_flags[1], status_flags[0]};
                checks++;
                if (status_byte !== e.sb) begin
                    errors++;
                    $display("FAIL %s status_byte: got %h expected %h", e.name, status_byte, e.sb);
                end
                checks++;
                if (af !== e.fl) begin
                    errors++;
                    $display("FAIL %s status_flags: got %b expected %b", e.name, af, e.fl);
                end
                checks++;
                if (alu_carry_in !== e.cin) begin
                    errors++;
                    $display("FAIL %s alu_carry_in: got %b expected %b", e.name, alu_carry_in, e.cin);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        for (int k = 0; k < CTRL_SIGNAL_COUNT; k++) ctrl[k] = 1'b0;
        data_bus = 8'h00;
        alu_carry_out = 1'b0;
        alu_overflow_out = 1'b0;
        brk_push = 1'b0;
        //            rst  strobes                                                           bus    co    ov    brk   expected  n v c z i d brk
        step(1'b1, 13'h0, 8'h00, 1'b0, 1'b0, 1'b0, ex("reset0",       0,0,0,0,1,0,0));
        step(1'b1, 13'h0, 8'h00, 1'b0, 1'b0, 1'b0, ex("reset1",       0,0,0,0,1,0,0));
        step(1'b0, m(CtrlUpdateFlagNegative) | m(CtrlUpdateFlagZero), 8'h80, 1'b0, 1'b0, 1'b0,
             ex("nz_80",        1,0,0,0,1,0,0));
        step(1'b0, m(CtrlUpdateFlagNegative) | m(CtrlUpdateFlagZero), 8'h00, 1'b0, 1'b0, 1'b0,
             ex("nz_00",        0,0,0,1,1,0,0));
        step(1'b0, m(CtrlUpdateFlagCarry) | m(CtrlUpdateFlagOverflow), 8'h00, 1'b1, 1'b1, 1'b0,
             ex("cv_alu",       0,1,1,1,1,0,0));
        step(1'b0, m(CtrlClearFlagCarry), 8'h00, 1'b0, 1'b0, 1'b0,
             ex("clc",          0,1,0,1,1,0,0));
        step(1'b0, m(CtrlSetFlagCarry) | m(CtrlClearFlagCarry), 8'h00, 1'b0, 1'b0, 1'b0,
             ex("sec_clc",      0,1,0,1,1,0,0));
        step(1'b0, m(CtrlSetFlagCarry), 8'h00, 1'b0, 1'b0, 1'b0,
             ex("sec",          0,1,1,1,1,0,0));
        step(1'b0, m(CtrlLoadStatus), 8'h01, 1'b0, 1'b0, 1'b0,
             ex("only_c",       0,0,1,0,0,0,0));
        step(1'b0, m(CtrlStatusBitTest) | m(CtrlUpdateFlagOverflow), 8'h40, 1'b0, 1'b0, 1'b0,
             ex("bit_40",       0,1,1,0,0,0,0));
        step(1'b0, m(CtrlLoadStatus), 8'hFF, 1'b0, 1'b0, 1'b0,
             ex("plp_ff",       1,1,1,1,1,1,0));
        step(1'b0, 13'h0, 8'h00, 1'b0, 1'b0, 1'b1,
             ex("push_brk",     1,1,1,1,1,1,1));
        step(1'b1, m(CtrlLoadStatus), 8'hFF, 1'b0, 1'b0, 1'b0,
             ex("reset_load",   0,0,0,0,1,0,0));
        step(1'b0, m(CtrlSetFlagCarry) | m(CtrlUpdateFlagZero), 8'h00, 1'b0, 1'b0, 1'b0,
             ex("sec_z",        0,0,1,1,1,0,0));
        step(1'b0, m(CtrlClearFlagInterrupt) | m(CtrlSetFlagDecimal), 8'h00, 1'b0, 1'b0, 1'b0,
             ex("cli_sed",      0,0,1,1,0,1,0));
        step(1'b0, m(CtrlClearFlagDecimal) | m(CtrlSetFlagDecimal) | m(CtrlSetFlagInterrupt),
             8'h00, 1'b0, 1'b0, 1'b0, ex("cld_sei",      0,0,1,1,1,0,0));
        step(1'b0, m(CtrlLoadStatus) | m(CtrlStatusBitTest) | m(CtrlUpdateFlagZero) | m(CtrlSetFlagCarry),
             8'h02, 1'b1, 1'b1, 1'b0, ex("load_prio",    0,0,0,1,0,0,0));
        step(1'b0, m(CtrlUpdateFlagOverflow), 8'h00, 1'b0, 1'b1, 1'b0,
             ex("v_set",        0,1,0,1,0,0,0));
        step(1'b0, m(CtrlClearFlagOverflow) | m(CtrlUpdateFlagOverflow), 8'h00, 1'b0, 1'b1, 1'b0,
             ex("clv_prio",     0,0,0,1,0,0,0));
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
